// File: rtl/floating_point_adder_normalizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : floating_point_adder_normalizer_if
//  Description : Valid/ready stream bundle for the FP adder normalization
//                stage: raw mantissa sum in, packed single-precision out.
//  Revision    : 1.0  initial release
// ============================================================================
interface floating_point_adder_normalizer_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant_sum;
    logic [4:0]  in_lz_count;
    logic        in_lz_all_zeros;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_zero;

    // Producer side: drives the raw sum, consumes the packed result.
    modport master (
        output in_valid, in_sign, in_exp, in_mant_sum, in_lz_count, in_lz_all_zeros,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_overflow, out_underflow, out_zero
    );

    // Normalizer side.
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant_sum, in_lz_count, in_lz_all_zeros,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_overflow, out_underflow, out_zero
    );
endinterface
`default_nettype wire

// File: rtl/floating_point_adder_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : floating_point_adder_normalizer
//  Description : Two-stage normalize-and-pack stage of the FP adder. Stage 1
//                captures the raw sum; stage 2 shifts, adjusts the exponent,
//                classifies overflow/underflow/zero and registers the
//                packed IEEE-754 single-precision result.
//  Revision    : 1.0  initial release
// ============================================================================
module floating_point_adder_normalizer (
    input  wire logic                          clk,
    input  wire logic                          rst,
    floating_point_adder_normalizer_if.slave   bus
);

    // Stage 1 holding register
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [7:0]  r_s1_exp;
    logic [24:0] r_s1_mant;
    logic [4:0]  r_s1_lz;
    logic        r_s1_allz;

    // Stage 2 / output register
    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic        r_out_overflow;
    logic        r_out_underflow;
    logic        r_out_zero;

    logic        w_adv1;
    logic        w_adv2;
    logic [8:0]  w_exp_inc;
    logic [7:0]  w_exp_sub;
    logic [22:0] w_norm_frac;
    logic [31:0] w_result;
    logic        w_overflow;
    logic        w_underflow;
    logic        w_zero;

    // A stage advances when its downstream slot is empty or being drained;
    // in_ready therefore depends combinationally on out_ready.
    assign w_adv2       = !r_out_valid || bus.out_ready;
    assign w_adv1       = !r_s1_valid || w_adv2;
    assign bus.in_ready = w_adv1;

    // Carry path needs the ninth bit to see exp+1 reach 255.
    assign w_exp_inc   = {1'b0, r_s1_exp} + 9'd1;
    // Only used when lz < exp, so the subtraction never borrows and 8 bits suffice.
    assign w_exp_sub   = r_s1_exp - {3'b000, r_s1_lz};
    // Bit 23 of the shifted mantissa is the hidden bit and is dropped, so
    // shifting only the low 23 bits yields the same fraction.
    assign w_norm_frac = r_s1_mant[22:0] << r_s1_lz;

    // Capture an accepted input beat; an empty slot loads a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= 8'd0;
            r_s1_mant  <= 25'd0;
            r_s1_lz    <= 5'd0;
            r_s1_allz  <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign <= bus.in_sign;
                r_s1_exp  <= bus.in_exp;
                r_s1_mant <= bus.in_mant_sum;
                r_s1_lz   <= bus.in_lz_count;
                r_s1_allz <= bus.in_lz_all_zeros;
            end
        end
    end

    // Classify the stage-1 beat (first match wins) and build the packed word.
    always_comb begin
        w_result    = 32'd0;
        w_overflow  = 1'b0;
        w_underflow = 1'b0;
        w_zero      = 1'b0;
        if (r_s1_exp == 8'hFF) begin
            w_result   = {r_s1_sign, 8'hFF, 23'd0};
            w_overflow = 1'b1;
        end else if (r_s1_mant[24]) begin
            if (w_exp_inc >= 9'd255) begin
                w_result   = {r_s1_sign, 8'hFF, 23'd0};
                w_overflow = 1'b1;
            end else begin
                w_result = {r_s1_sign, w_exp_inc[7:0], r_s1_mant[23:1]};
            end
        end else if (r_s1_allz || (r_s1_mant[23:0] == 24'd0)) begin
            // Exact cancellation always packs as +0.
            w_zero = 1'b1;
        end else if ({3'b000, r_s1_lz} >= r_s1_exp) begin
            // No subnormal support: flush to signed zero.
            w_result    = {r_s1_sign, 31'd0};
            w_underflow = 1'b1;
        end else begin
            w_result = {r_s1_sign, w_exp_sub, w_norm_frac};
        end
    end

    // Register the result; hold it while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid     <= 1'b0;
            r_out_result    <= 32'd0;
            r_out_overflow  <= 1'b0;
            r_out_underflow <= 1'b0;
            r_out_zero      <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_result    <= w_result;
                r_out_overflow  <= w_overflow;
                r_out_underflow <= w_underflow;
                r_out_zero      <= w_zero;
            end
        end
    end

    assign bus.out_valid     = r_out_valid;
    assign bus.out_result    = r_out_result;
    assign bus.out_overflow  = r_out_overflow;
    assign bus.out_underflow = r_out_underflow;
    assign bus.out_zero      = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_floating_point_adder_normalizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floating_point_adder_normalizer
//  Description : Self-checking bench for the FP adder normalizer: directed
//                corner cases, backpressure, mid-stream reset and random
//                traffic against an arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_floating_point_adder_normalizer;

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    floating_point_adder_normalizer_if nif ();

    floating_point_adder_normalizer dut (
        .clk (clk),
        .rst (rst),
        .bus (nif)
    );

    // Leading zeros of the 24-bit field below the carry bit.
    function automatic int clz24(input logic [24:0] m);
        for (int i = 23; i >= 0; i--)
            if (m[i]) return 23 - i;
        return 24;
    endfunction

    // Reference: the classification rules evaluated with plain integer math.
    function automatic exp_t ref_model(input logic s, input logic [7:0] e,
                                       input logic [24:0] m, input logic [4:0] lz,
                                       input logic az);
        exp_t   r;
        longint en;
        longint frac;
        r = '0;
        if (e == 8'd255) begin
            r.res = {s, 8'hFF, 23'h0};
            r.ovf = 1'b1;
        end else if (longint'(m) >= 64'd16777216) begin
            en = longint'(e) + 1;
            if (en >= 255) begin
                r.res = {s, 8'hFF, 23'h0};
                r.ovf = 1'b1;
            end else begin
                frac  = (longint'(m) % 16777216) / 2;
                r.res = {s, 8'(en), 23'(frac)};
            end
        end else if (az || m == 25'd0) begin
            r.zero = 1'b1;
        end else if (longint'(lz) >= longint'(e)) begin
            r.res = {s, 31'h0};
            r.unf = 1'b1;
        end else begin
            en    = longint'(e) - longint'(lz);
            frac  = (longint'(m) << lz) % 8388608;
            r.res = {s, 8'(en), 23'(frac)};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] e, input logic [24:0] m);
        nif.in_valid        = v;
        nif.in_sign         = s;
        nif.in_exp          = e;
        nif.in_mant_sum     = m;
        nif.in_lz_count     = 5'(clz24(m));
        nif.in_lz_all_zeros = (m[23:0] == 24'd0);
    endtask

    // One clock: sample handshakes on the falling edge, score the output,
    // then return 1 ns after the rising edge.
    task automatic step(output bit acc);
        bit   fire;
        exp_t e;
        fire = 1'b0;
        @(negedge clk);
        acc = nif.in_valid && nif.in_ready;
        if (nif.out_valid) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_out observed=valid expected=no_pending_beat");
            end
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("sb_result", nif.out_result, e.res);
                check("sb_flags", {29'd0, nif.out_overflow, nif.out_underflow, nif.out_zero},
                      {29'd0, e.ovf, e.unf, e.zero});
            end
            fire = nif.out_ready;
        end
        if (acc)
            exp_q.push_back(ref_model(nif.in_sign, nif.in_exp, nif.in_mant_sum,
                                      nif.in_lz_count, nif.in_lz_all_zeros));
        @(posedge clk);
        #1;
        if (fire && exp_q.size() != 0)
            void'(exp_q.pop_front());
    endtask

    // Single beat through an idle pipe with literal expected output.
    task automatic single(input string tag, input logic s, input logic [7:0] e,
                          input logic [24:0] m, input logic [31:0] want,
                          input logic [2:0] want_flags);
        bit acc;
        nif.out_ready = 1'b1;
        drive(1'b1, s, e, m);
        step(acc);
        check({tag, "_accept"}, 32'(acc), 32'd1);
        nif.in_valid = 1'b0;
        check({tag, "_valid_early"}, 32'(nif.out_valid), 32'd0);
        step(acc);
        check({tag, "_valid"}, 32'(nif.out_valid), 32'd1);
        check({tag, "_result"}, nif.out_result, want);
        check({tag, "_flags"}, {29'd0, nif.out_overflow, nif.out_underflow, nif.out_zero},
              {29'd0, want_flags});
        step(acc);
    endtask

    initial begin
        bit         acc;
        bit         saw_block;
        int         sent;
        int         kind;
        logic [7:0] e;
        logic [24:0] m;

        rst = 1'b1;
        nif.out_ready = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 25'd0);
        @(posedge clk);
        #1;
        check("reset_out_valid", 32'(nif.out_valid), 32'd0);
        check("reset_in_ready", 32'(nif.in_ready), 32'd1);
        check("reset_result", nif.out_result, 32'd0);
        check("reset_flags", {29'd0, nif.out_overflow, nif.out_underflow, nif.out_zero}, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases (flags ordered ovf, unf, zero)
        single("carry",     1'b0, 8'd127, 25'h1000000, 32'h40000000, 3'b000);
        single("left_norm", 1'b0, 8'd127, 25'h0000400, 32'h39000000, 3'b000);
        single("cancel",    1'b1, 8'd100, 25'h0000000, 32'h00000000, 3'b001);
        single("underflow", 1'b1, 8'd5,   25'h0000400, 32'h80000000, 3'b010);
        single("ovf_carry", 1'b0, 8'd254, 25'h1800000, 32'h7F800000, 3'b100);
        single("ovf_exp",   1'b0, 8'd255, 25'h0800000, 32'h7F800000, 3'b100);

        // Backpressure: 4 beats back-to-back, consumer stalled cycles 2-5
        sent = 0;
        saw_block = 1'b0;
        for (int c = 0; c < 14; c++) begin
            nif.out_ready = !(c >= 1 && c <= 4);
            if (sent < 4)
                drive(1'b1, 1'(sent & 1), 8'(100 + sent), 25'h0800000 | 25'(sent << 4));
            else
                nif.in_valid = 1'b0;
            #2;
            if (nif.in_valid && !nif.in_ready) saw_block = 1'b1;
            step(acc);
            if (acc) sent++;
        end
        check("bp_in_ready_dropped", 32'(saw_block), 32'd1);
        check("bp_all_accepted", 32'(sent), 32'd4);
        check("bp_all_delivered", 32'(exp_q.size()), 32'd0);

        // Reset with two beats in flight
        nif.out_ready = 1'b0;
        drive(1'b1, 1'b0, 8'd60, 25'h0C00000);
        step(acc);
        drive(1'b1, 1'b1, 8'd61, 25'h0A00000);
        step(acc);
        nif.in_valid = 1'b0;
        check("pre_rst_valid", 32'(nif.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(nif.out_valid), 32'd0);
        check("rst_result", nif.out_result, 32'd0);
        check("rst_flags", {29'd0, nif.out_overflow, nif.out_underflow, nif.out_zero}, 32'd0);
        check("rst_in_ready", 32'(nif.in_ready), 32'd1);
        exp_q.delete();
        step(acc);
        step(acc);
        #2 rst = 1'b0;
        nif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("post_rst_idle", 32'(nif.out_valid), 32'd0);
        end
        single("rst_recover", 1'b1, 8'd130, 25'h0400000, 32'hC0800000, 3'b000);

        // Random traffic with random stalls
        for (int c = 0; c < 400; c++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0:       m = 25'h1000000 | 25'($urandom & 32'hFFFFFF);
                1:       m = 25'd0;
                2:       m = 25'($urandom % 256);
                default: m = 25'($urandom & 32'hFFFFFF);
            endcase
            e = ($urandom_range(0, 7) == 0) ? 8'(250 + $urandom_range(0, 5))
                                            : 8'($urandom_range(0, 255));
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom & 1), e, m);
            nif.out_ready = 1'($urandom_range(0, 2) != 0);
            step(acc);
        end
        nif.in_valid  = 1'b0;
        nif.out_ready = 1'b1;
        for (int i = 0; i < 20 && (exp_q.size() != 0 || nif.out_valid); i++)
            step(acc);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/floating_point_adder_normalizer.md
# floating_point_adder_normalizer

Post-addition normalization and packing stage of the floating-point adder. Consumes the raw 25-bit mantissa sum with the leading-zero count and all-zeros flag from the adder's leading-zeros counter. It shifts the mantissa, adjusts the exponent, detects overflow, underflow and zero, and emits a packed IEEE-754 single-precision result. Two-stage pipeline with valid/ready handshaking toward the belief-propagation datapath.

## Interface
- No parameters (widths fixed to single precision).
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat present
- in_ready  output  1  stage can accept input this cycle
- in_sign  input  1  sign of the sum
- in_exp  input  8  biased exponent of the larger operand
- in_mant_sum  input  25  raw mantissa sum; bit 24 = carry-out, bit 23 = hidden-bit position
- in_lz_count  input  5  leading zeros of in_mant_sum[23:0], range 0..24
- in_lz_all_zeros  input  1  high when in_mant_sum[23:0] == 0
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_result  output  32  packed {sign, exp[7:0], frac[22:0]}
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to signed zero
- out_zero  output  1  exact zero result (cancellation)

## Operation
- Stage 1 registers the accepted input beat when in_valid && in_ready.
- Stage 2 computes and registers the result and flags from the stage-1 contents. Classification priority, first match wins:
  - in_exp == 255: result {sign, 8'hFF, 23'h0}, overflow = 1.
  - mant_sum[24] == 1 (carry): exp_n = exp + 1 (9-bit); frac = mant_sum[23:1] (truncate). If exp_n >= 255: result {sign, 8'hFF, 0}, overflow = 1.
  - mant_sum[24] == 0 and all_zeros == 1 (or mant_sum[24:0] == 0): result 32'h00000000 (+0 regardless of sign), zero = 1. lz_count is ignored.
  - Otherwise, if lz_count >= exp: result {sign, 31'h0}, underflow = 1. No subnormals.
  - Otherwise: exp_n = exp − lz_count; shifted = mant_sum[23:0] << lz_count; frac = shifted[22:0]; result {sign, exp_n[7:0], frac}.
- in_lz_count is ignored whenever mant_sum[24] == 1.
- Rounding: truncation (round toward zero) only.
- At most one of overflow, underflow or zero is high per result.
- Exponent arithmetic uses 9-bit intermediates. No wrap-around reaches out_result.

## Timing
- Latency: 2 cycles from the accepting edge to out_valid, with no stall.
- Throughput: 1 result per cycle.
- adv2 = !out_valid || out_ready.
- adv1 = !s1_valid || adv2.
- in_ready = adv1. This is a combinational path from out_ready.
- While out_valid && !out_ready, out_result and all flags hold stable.
- No beat is dropped or duplicated, and order is preserved.
- With both stages full and out_ready low, in_ready = 0.
- Simultaneous out_ready and in_valid with a full pipeline: both stages advance and a new beat is accepted the same cycle.
- Reset (asynchronous, any time, including mid-stream):
  - s1_valid, out_valid, out_result, and all flags go to 0 immediately.
  - In-flight beats are discarded.
  - in_ready reads 1 while rst is high and after release.
- out_valid never asserts while rst is high.

## Test plan
- Carry normalize: sign 0, exp 127, mant_sum 25'h1000000 -> 2 cycles later out_result 32'h40000000, all flags 0.
- Left normalize: sign 0, exp 127, mant_sum 25'h0000400, lz 13 -> out_result 32'h39000000, flags 0.
- Cancellation and underflow:
  - sign 1, mant_sum 0, all_zeros 1 -> 32'h00000000, out_zero 1.
  - sign 1, exp 5, mant_sum 25'h0000400, lz 13 -> 32'h80000000, out_underflow 1.
- Overflow: sign 0, exp 254, mant_sum 25'h1800000 -> 32'h7F800000, out_overflow 1. Also exp 255 input -> 32'h7F800000, out_overflow 1.
- Backpressure: stream 4 beats back-to-back with out_ready low for cycles 2–5.
  - in_ready drops once both stages are full.
  - out_result stays stable while stalled.
  - All 4 results emerge in order with no loss once out_ready returns high.
- Reset mid-stream: assert rst asynchronously with 2 beats in flight.
  - out_valid and outputs drop to 0 within the same cycle.
  - After release, out_valid stays 0 until a new beat is accepted, then asserts 2 cycles later with the correct result.
